// File: rtl/div_seq_pkg.sv
// Shared definitions for the iterative RV64 divider: widths, opcodes, FSM states
// and operand extension helpers.
package div_seq_pkg;

  localparam int XLEN = 64;
  localparam int AW   = XLEN + 1;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_NEG_A = 3'd1,
    ST_NEG_B = 3'd2,
    ST_ITER  = 3'd3,
    ST_FIX   = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  // Sign-extend a 32-bit value to XLEN.
  function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
    return {{(XLEN-32){v[31]}}, v};
  endfunction

  // W forms use only the low word, sign- or zero-extended by op signedness.
  function automatic logic [XLEN-1:0] ext_operand(input logic [XLEN-1:0] v,
                                                  input logic word,
                                                  input logic is_signed);
    logic [XLEN-1:0] r;
    if (word) begin
      if (is_signed) r = sext32(v[31:0]);
      else           r = {{(XLEN-32){1'b0}}, v[31:0]};
    end else begin
      r = v;
    end
    return r;
  endfunction

endpackage

// File: rtl/div_seq_cla_add.sv
// Carry-lookahead adder built as a tree of 4-bit group lookahead units.
// Supports WIDTH up to 256 bits (four lookahead levels).

// 4-bit group lookahead unit: internal carries plus group generate/propagate.
module cla_lau (
  input  logic [3:0] g,
  input  logic [3:0] p,
  input  logic       cin,
  output logic [3:0] c,
  output logic       gg,
  output logic       pg
);
  assign c[0] = cin;
  assign c[1] = g[0] | (p[0] & cin);
  assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
  assign gg   = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
  assign pg   = &p;
endmodule

module cla_add #(
  parameter int WIDTH = 65
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int NG1 = (WIDTH + 3) / 4;
  localparam int NG2 = (NG1 + 3) / 4;
  localparam int NG3 = (NG2 + 3) / 4;

  logic [4*NG1-1:0] g0, p0, c0;
  logic [4*NG2-1:0] g1, p1, c1;
  logic [4*NG3-1:0] g2, p2, c2;
  logic [3:0]       g3, p3, c3;
  logic             unused_top_g, unused_top_p, unused_pad_carries;

  // Bit-level generate/propagate; positions above WIDTH are neutral padding.
  for (genvar i = 0; i < 4*NG1; i++) begin : g_bit
    if (i < WIDTH) begin : g_real
      assign g0[i] = a[i] & b[i];
      assign p0[i] = a[i] ^ b[i];
    end else begin : g_pad
      assign g0[i] = 1'b0;
      assign p0[i] = 1'b0;
    end
  end

  for (genvar j = 0; j < 4*NG2; j++) begin : g_lvl1
    if (j < NG1) begin : g_unit
      cla_lau u_lau (.g(g0[4*j +: 4]), .p(p0[4*j +: 4]), .cin(c1[j]),
                     .c(c0[4*j +: 4]), .gg(g1[j]), .pg(p1[j]));
    end else begin : g_pad
      assign g1[j] = 1'b0;
      assign p1[j] = 1'b0;
    end
  end

  for (genvar k = 0; k < 4*NG3; k++) begin : g_lvl2
    if (k < NG2) begin : g_unit
      cla_lau u_lau (.g(g1[4*k +: 4]), .p(p1[4*k +: 4]), .cin(c2[k]),
                     .c(c1[4*k +: 4]), .gg(g2[k]), .pg(p2[k]));
    end else begin : g_pad
      assign g2[k] = 1'b0;
      assign p2[k] = 1'b0;
    end
  end

  for (genvar m = 0; m < 4; m++) begin : g_lvl3
    if (m < NG3) begin : g_unit
      cla_lau u_lau (.g(g2[4*m +: 4]), .p(p2[4*m +: 4]), .cin(c3[m]),
                     .c(c2[4*m +: 4]), .gg(g3[m]), .pg(p3[m]));
    end else begin : g_pad
      assign g3[m] = 1'b0;
      assign p3[m] = 1'b0;
    end
  end

  cla_lau u_top (.g(g3), .p(p3), .cin(cin), .c(c3), .gg(unused_top_g), .pg(unused_top_p));

  assign sum  = p0[WIDTH-1:0] ^ c0[WIDTH-1:0];
  assign cout = g0[WIDTH-1] | (p0[WIDTH-1] & c0[WIDTH-1]);

  // Carries into padding positions have no consumer.
  assign unused_pad_carries = ^{c0, c1, c2, c3};
endmodule

// File: rtl/div_seq.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU and W forms. One shared
// carry-lookahead adder does operand negation, the per-bit trial subtract and
// the final sign fix-up; the FSM steers its operand muxes.
module div_seq
  import div_seq_pkg::*;
(
  input  logic            clock,
  input  logic            reset,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      op,
  input  logic            word,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result
);

  state_e          state_r, state_nx_s;
  logic [6:0]      cnt_r;
  logic [XLEN-1:0] rem_r, quo_r, div_r, result_r;
  logic            word_r, is_rem_r, neg_a_r, neg_b_r, out_valid_r;

  op_e             op_s;
  logic            signed_op_s, rem_op_s, accept_s, div_zero_s, ovf_s, quo_msb_s, fix_neg_s;
  logic [XLEN-1:0] a_ext_s, b_ext_s, min_neg_s, special_raw_s, special_res_s;
  logic [XLEN-1:0] fix_val_s, fix_res_s, fix_out_s;
  logic [AW-1:0]   rem_sh_s, add_a_s, add_b_s, add_sum_s;
  logic            add_cin_s, add_cout_s;

  assign op_s        = op_e'(op);
  assign signed_op_s = (op_s == OP_DIV) || (op_s == OP_REM);
  assign rem_op_s    = (op_s == OP_REM) || (op_s == OP_REMU);
  assign a_ext_s     = ext_operand(src1, word, signed_op_s);
  assign b_ext_s     = ext_operand(src2, word, signed_op_s);
  assign min_neg_s   = word ? {{(XLEN-31){1'b1}}, {31{1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
  assign div_zero_s  = (b_ext_s == {XLEN{1'b0}});
  assign ovf_s       = signed_op_s && (a_ext_s == min_neg_s) && (b_ext_s == {XLEN{1'b1}});
  assign in_ready    = (state_r == ST_IDLE) && !flush && !reset;
  assign accept_s    = in_valid && in_ready;

  // Divide-by-zero and overflow results are known at accept time.
  assign special_raw_s = div_zero_s ? (rem_op_s ? a_ext_s : {XLEN{1'b1}})
                                    : (rem_op_s ? {XLEN{1'b0}} : a_ext_s);
  assign special_res_s = word ? sext32(special_raw_s[31:0]) : special_raw_s;

  // Next dividend bit to shift into the partial remainder.
  assign quo_msb_s = word_r ? quo_r[31] : quo_r[XLEN-1];
  assign rem_sh_s  = {rem_r, quo_msb_s};

  // Fix-up: quotient sign is the XOR of operand signs, remainder follows the dividend.
  assign fix_val_s = is_rem_r ? rem_r : quo_r;
  assign fix_neg_s = is_rem_r ? neg_a_r : (neg_a_r ^ neg_b_r);
  assign fix_res_s = fix_neg_s ? add_sum_s[XLEN-1:0] : fix_val_s;
  assign fix_out_s = word_r ? sext32(fix_res_s[31:0]) : fix_res_s;

  // Operand muxes of the shared adder: negation is 0 + ~x + 1, trial subtract is rem_sh + ~div + 1.
  always_comb begin
    add_a_s   = {AW{1'b0}};
    add_b_s   = {AW{1'b0}};
    add_cin_s = 1'b0;
    case (state_r)
      ST_NEG_A: begin
        add_b_s   = ~{1'b0, quo_r};
        add_cin_s = 1'b1;
      end
      ST_NEG_B: begin
        add_b_s   = ~{1'b0, div_r};
        add_cin_s = 1'b1;
      end
      ST_ITER: begin
        add_a_s   = rem_sh_s;
        add_b_s   = ~{1'b0, div_r};
        add_cin_s = 1'b1;
      end
      ST_FIX: begin
        add_b_s   = ~{1'b0, fix_val_s};
        add_cin_s = 1'b1;
      end
      default: begin
        add_cin_s = 1'b0;
      end
    endcase
  end

  cla_add #(.WIDTH(AW)) u_add (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // Next-state logic; flush aborts from any state.
  always_comb begin
    state_nx_s = state_r;
    if (flush) begin
      state_nx_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) state_nx_s = (div_zero_s || ovf_s) ? ST_DONE : ST_NEG_A;
          else          state_nx_s = ST_IDLE;
        end
        ST_NEG_A: state_nx_s = ST_NEG_B;
        ST_NEG_B: state_nx_s = ST_ITER;
        ST_ITER: begin
          if (cnt_r == 7'd0) state_nx_s = ST_FIX;
          else               state_nx_s = ST_ITER;
        end
        ST_FIX: state_nx_s = ST_DONE;
        ST_DONE: begin
          if (out_ready) state_nx_s = ST_IDLE;
          else           state_nx_s = ST_DONE;
        end
        default: state_nx_s = ST_IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clock) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_nx_s;
  end

  // Datapath registers: operand capture, negation, restoring iteration and result.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_r       <= 7'd0;
      out_valid_r <= 1'b0;
      result_r    <= {XLEN{1'b0}};
    end else if (flush) begin
      cnt_r       <= 7'd0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            quo_r    <= a_ext_s;
            div_r    <= b_ext_s;
            rem_r    <= {XLEN{1'b0}};
            word_r   <= word;
            is_rem_r <= rem_op_s;
            neg_a_r  <= signed_op_s && a_ext_s[XLEN-1];
            neg_b_r  <= signed_op_s && b_ext_s[XLEN-1];
            cnt_r    <= word ? 7'd31 : 7'd63;
            if (div_zero_s || ovf_s) begin
              result_r    <= special_res_s;
              out_valid_r <= 1'b1;
            end
          end
        end
        ST_NEG_A: begin
          if (neg_a_r) quo_r <= add_sum_s[XLEN-1:0];
        end
        ST_NEG_B: begin
          if (neg_b_r) div_r <= add_sum_s[XLEN-1:0];
        end
        ST_ITER: begin
          rem_r <= add_cout_s ? add_sum_s[XLEN-1:0] : rem_sh_s[XLEN-1:0];
          quo_r <= {quo_r[XLEN-2:0], add_cout_s};
          if (cnt_r != 7'd0) cnt_r <= cnt_r - 7'd1;
        end
        ST_FIX: begin
          result_r    <= fix_out_s;
          out_valid_r <= 1'b1;
        end
        ST_DONE: begin
          if (out_ready) out_valid_r <= 1'b0;
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = out_valid_r;
  assign result    = result_r;

endmodule

// File: tb/tb_div_seq.sv
// Directed self-checking bench for div_seq: results, latency, handshake stall,
// flush and mid-operation reset.
module tb_div_seq;

  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, word, out_valid, out_ready;
  logic [1:0]  op;
  logic [63:0] src1, src2, result;

  int err_cnt = 0;
  int chk_cnt = 0;

  typedef struct {
    logic [1:0]  op;
    logic        w;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clock = ~clock;

  div_seq dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .word      (word),
    .src1      (src1),
    .src2      (src2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] o, input logic w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] e, input int l);
    vec_t v;
    v.op = o; v.w = w; v.a = a; v.b = b; v.exp = e; v.lat = l;
    vecs.push_back(v);
  endtask

  // Present a request at a falling edge; returns after the accepting rising edge, with lat = 1.
  task automatic issue(input string tag, input logic [1:0] o, input logic w,
                       input logic [63:0] a, input logic [63:0] b, output int lat);
    @(negedge clock);
    op = o; word = w; src1 = a; src2 = b; in_valid = 1'b1;
    check_eq({tag, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    in_valid = 1'b0;
  endtask

  // Issue, wait (bounded) for out_valid, then check latency and result.
  task automatic run(input string tag, input logic [1:0] o, input logic w, input logic [63:0] a,
                     input logic [63:0] b, input logic [63:0] e, input int exp_lat);
    int lat;
    issue(tag, o, w, a, b, lat);
    while (!out_valid && lat < 150) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_res"}, result, e);
  endtask

  // With out_ready high the result is consumed at the next edge; divider must be ready again.
  task automatic consume(input string tag);
    out_ready = 1'b1;
    @(posedge clock);
    @(negedge clock);
    check_eq({tag, "_ov_clr"}, 64'(out_valid), 64'd0);
    check_eq({tag, "_rdy_back"}, 64'(in_ready), 64'd1);
  endtask

  initial begin
    int lat;
    int seen;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    op = 2'b00; word = 1'b0; src1 = 64'd0; src2 = 64'd0;

    // Reset state
    repeat (2) @(negedge clock);
    check_eq("rst_in_ready", 64'(in_ready), 64'd0);
    check_eq("rst_out_valid", 64'(out_valid), 64'd0);
    check_eq("rst_result", result, 64'd0);
    reset = 1'b0;
    #1;
    check_eq("post_rst_in_ready", 64'(in_ready), 64'd1);

    add_vec(2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 68);
    add_vec(2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 68);
    add_vec(2'b00, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 68);
    add_vec(2'b10, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 68);
    add_vec(2'b10, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 68);
    add_vec(2'b01, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1);
    add_vec(2'b10, 1'b0, 64'd5, 64'd0, 64'd5, 1);
    add_vec(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 1);
    add_vec(2'b10, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    add_vec(2'b00, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    add_vec(2'b00, 1'b1, 64'h1234_5678_FFFF_FFF8, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 36);
    add_vec(2'b11, 1'b1, 64'h0000_0000_FFFF_FFFF, 64'd10, 64'd5, 36);
    add_vec(2'b01, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd3, 64'h5555_5555_5555_5555, 68);
    add_vec(2'b00, 1'b0, 64'h8000_0000_0000_0000, 64'd2, 64'hC000_0000_0000_0000, 68);

    foreach (vecs[i]) begin
      run($sformatf("vec%0d", i), vecs[i].op, vecs[i].w, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
      consume($sformatf("vec%0d", i));
    end

    // Consumer stalls 5 cycles in DONE: result and out_valid must hold.
    out_ready = 1'b0;
    run("stall", 2'b01, 1'b0, 64'd100, 64'd7, 64'd14, 68);
    for (int i = 0; i < 5; i++) begin
      check_eq($sformatf("stall_ov%0d", i), 64'(out_valid), 64'd1);
      check_eq($sformatf("stall_res%0d", i), result, 64'd14);
      check_eq($sformatf("stall_rdy%0d", i), 64'(in_ready), 64'd0);
      @(negedge clock);
    end
    consume("stall");
    run("after_stall", 2'b11, 1'b0, 64'd100, 64'd7, 64'd2, 68);
    consume("after_stall");

    // Flush at T+20.
    issue("flush", 2'b01, 1'b0, 64'd100, 64'd7, lat);
    repeat (19) @(negedge clock);
    flush = 1'b1;
    #1;
    check_eq("flush_rdy_low", 64'(in_ready), 64'd0);
    @(negedge clock);
    flush = 1'b0;
    #1;
    check_eq("flush_rdy_back", 64'(in_ready), 64'd1);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check_eq("flush_no_ov", 64'(seen), 64'd0);

    // Reset at T+30, then a fresh operation.
    issue("rst_mid", 2'b01, 1'b0, 64'd100, 64'd7, lat);
    repeat (29) @(negedge clock);
    reset = 1'b1;
    #1;
    check_eq("rst_mid_rdy_low", 64'(in_ready), 64'd0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_eq("rst_mid_rdy_back", 64'(in_ready), 64'd1);
    check_eq("rst_mid_ov", 64'(out_valid), 64'd0);
    seen = 0;
    for (int i = 0; i < 70; i++) begin
      @(negedge clock);
      if (out_valid) seen++;
    end
    check_eq("rst_mid_no_ov", 64'(seen), 64'd0);
    run("post_rst", 2'b01, 1'b0, 64'd9, 64'd3, 64'd3, 68);
    consume("post_rst");

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
